// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller:
// the state encoding, the default PC step and PC alignment.
package fetch_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned PC_STEP_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_BUBBLE = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that holds the read word which arrives while decode is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inst
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues word addresses to a one-cycle-latency memory and
// presents instructions to decode with a valid/ready handshake, prediction and redirect.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_cnt,
    output logic [1:0]  dbg_state
);

    // Handshake: an instruction moves to decode in a cycle where if_valid && id_ready;
    // if_pc/if_inst are held stable while if_valid is high and id_ready is low.

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_e r_state;
    logic [31:0]  r_addr;
    logic         r_fly_v;
    logic         r_out_v;
    logic         r_out_mem;
    logic [31:0]  r_out_pc;
    logic [31:0]  r_out_inst;
    logic [31:0]  r_cnt;

    logic         w_xfer;
    logic         w_out_free;
    logic         w_arrive_v;
    logic         w_pend_v;
    logic [31:0]  w_pend_pc;
    logic [31:0]  w_pend_inst;
    logic         w_sk_v;
    logic [31:0]  w_sk_pc;
    logic [31:0]  w_sk_inst;
    logic         w_sk_load;

    assign w_xfer     = r_out_v && id_ready;
    assign w_out_free = !r_out_v || id_ready;
    // A word is arriving that the output is not already showing straight from memory.
    // Such a word always belongs to the address still on mem_addr, which is held in HOLD.
    assign w_arrive_v  = r_fly_v && !r_out_mem;
    assign w_pend_v    = w_sk_v || w_arrive_v;
    assign w_pend_pc   = w_sk_v ? w_sk_pc   : r_addr;
    assign w_pend_inst = w_sk_v ? w_sk_inst : mem_rdata;
    assign w_sk_load   = !redirect_valid && !w_out_free && w_arrive_v;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect_valid),
        .i_load  (w_sk_load),
        .i_pop   (w_out_free),
        .i_pc    (r_addr),
        .i_inst  (mem_rdata),
        .o_valid (w_sk_v),
        .o_pc    (w_sk_pc),
        .o_inst  (w_sk_inst)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RST;
            r_addr     <= RESET_PC;
            r_fly_v    <= 1'b0;
            r_out_v    <= 1'b0;
            r_out_mem  <= 1'b0;
            r_out_pc   <= RESET_PC;
            r_out_inst <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_xfer) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (redirect_valid) begin
                r_state   <= ST_BUBBLE;
                r_out_v   <= 1'b0;
                r_out_mem <= 1'b0;
                r_fly_v   <= 1'b0;
                r_addr    <= align_pc(redirect_pc);
            end else if (w_xfer && pred_taken) begin
                r_state   <= ST_BUBBLE;
                r_out_v   <= 1'b0;
                r_out_mem <= 1'b0;
                r_fly_v   <= 1'b0;
                r_addr    <= align_pc(pred_target);
            end else if (w_out_free) begin
                r_state <= ST_RUN;
                r_out_v <= 1'b1;
                if (w_pend_v) begin
                    // The read on mem_addr this cycle repeats the pending word, so it is not used.
                    r_out_pc   <= w_pend_pc;
                    r_out_inst <= w_pend_inst;
                    r_out_mem  <= 1'b0;
                    r_fly_v    <= 1'b0;
                    r_addr     <= w_pend_pc + STEP;
                end else begin
                    r_out_pc  <= r_addr;
                    r_out_mem <= 1'b1;
                    r_fly_v   <= 1'b1;
                    r_addr    <= r_addr + STEP;
                end
            end else begin
                r_state <= ST_HOLD;
                if (r_out_mem) begin
                    r_out_inst <= mem_rdata;
                    r_out_mem  <= 1'b0;
                end
                r_fly_v <= !w_pend_v;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign if_valid  = r_out_v;
    assign if_pc     = r_out_pc;
    assign if_inst   = r_out_mem ? mem_rdata : r_out_inst;
    assign fetch_cnt = r_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus a randomized run
// checked against a stream-level model of the fetch sequence.
module tb_inst_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_ready;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] mem_addr, mem_rdata, if_pc, if_inst, fetch_cnt;
    logic        if_valid;
    logic [1:0]  dbg_state;
    logic [31:0] mem_addr_w, mem_rdata_w, if_pc_w, if_inst_w, fetch_cnt_w;
    logic        if_valid_w;
    logic [1:0]  dbg_state_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) begin
        mem_rdata   <= mem_fn(mem_addr);
        mem_rdata_w <= mem_fn(mem_addr_w);
    end

    inst_fetch_ctrl dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_cnt(fetch_cnt), .dbg_state(dbg_state)
    );

    inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
        .if_valid(if_valid_w), .if_pc(if_pc_w), .if_inst(if_inst_w), .id_ready(id_ready),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_cnt(fetch_cnt_w), .dbg_state(dbg_state_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic pt, input logic [31:0] tgt,
                         input logic rv, input logic [31:0] rpc);
        id_ready       = rdy;
        pred_taken     = pt;
        pred_target    = tgt;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Leaves the bench in the first cycle after release, with reset already low.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        n_vec++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_out: got v=%b pc=%h inst=%h addr=%h exp 0/0/0/0", if_valid, if_pc, if_inst, mem_addr);
        end
        n_vec++;
        if (fetch_cnt !== 32'h0 || dbg_state !== 2'(ST_RST)) begin
            n_err++;
            $display("FAIL reset_cnt_state: got cnt=%h st=%0d exp 0/%0d", fetch_cnt, dbg_state, ST_RST);
        end
        n_vec++;
        if (if_pc_w !== 32'hFFFF_FFF8 || mem_addr_w !== 32'hFFFF_FFF8) begin
            n_err++;
            $display("FAIL reset_pc_param: got pc=%h addr=%h exp fffffff8", if_pc_w, mem_addr_w);
        end
        tick();
        reset = 1'b0;
        n_vec++;
        if (if_valid !== 1'b0 || mem_addr !== 32'h0 || dbg_state !== 2'(ST_RST)) begin
            n_err++;
            $display("FAIL rst_cycle: got v=%b addr=%h st=%0d exp v=0 addr=0 st=%0d", if_valid, mem_addr, dbg_state, ST_RST);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            e = 32'(4 * i);
            n_vec++;
            if (if_valid !== 1'b1 || if_pc !== e || if_inst !== mem_fn(e) || fetch_cnt !== 32'(i)) begin
                n_err++;
                $display("FAIL seq_fetch[%0d]: got v=%b pc=%h inst=%h cnt=%0d exp v=1 pc=%h inst=%h cnt=%0d",
                         i, if_valid, if_pc, if_inst, fetch_cnt, e, mem_fn(e), i);
            end
        end
        tick();
        n_vec++;
        if (fetch_cnt !== 32'd3 || if_pc !== 32'hC) begin
            n_err++;
            $display("FAIL seq_cnt: got cnt=%0d pc=%h exp cnt=3 pc=0000000c", fetch_cnt, if_pc);
        end
    endtask

    task automatic test_hold_release();
        logic [31:0] e;
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        tick();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== mem_fn(32'h8) ||
                mem_addr !== 32'hC || dbg_state !== 2'(ST_HOLD)) begin
                n_err++;
                $display("FAIL hold[%0d]: got v=%b pc=%h inst=%h addr=%h st=%0d exp v=1 pc=8 inst=%h addr=c st=%0d",
                         i, if_valid, if_pc, if_inst, mem_addr, dbg_state, mem_fn(32'h8), ST_HOLD);
            end
        end
        id_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = 32'hC + 32'(4 * i);
            n_vec++;
            if (if_valid !== 1'b1 || if_pc !== e || if_inst !== mem_fn(e)) begin
                n_err++;
                $display("FAIL hold_release[%0d]: got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                         i, if_valid, if_pc, if_inst, e, mem_fn(e));
            end
        end
        n_vec++;
        if (fetch_cnt !== 32'd4) begin
            n_err++;
            $display("FAIL hold_cnt: got %0d exp 4", fetch_cnt);
        end
    endtask

    task automatic test_pred_taken();
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (if_valid !== 1'b1 || if_pc !== 32'h10) begin
            n_err++;
            $display("FAIL pred_setup: got v=%b pc=%h exp v=1 pc=00000010", if_valid, if_pc);
        end
        drive(1'b1, 1'b1, 32'h43, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        n_vec++;
        if (if_valid !== 1'b0 || mem_addr !== 32'h40 || fetch_cnt !== 32'd5) begin
            n_err++;
            $display("FAIL pred_bubble: got v=%b addr=%h cnt=%0d exp v=0 addr=40 cnt=5", if_valid, mem_addr, fetch_cnt);
        end
        tick();
        n_vec++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== mem_fn(32'h40)) begin
            n_err++;
            $display("FAIL pred_target: got v=%b pc=%h inst=%h exp v=1 pc=40 inst=%h", if_valid, if_pc, if_inst, mem_fn(32'h40));
        end
        tick();
        n_vec++;
        if (if_valid !== 1'b1 || if_pc !== 32'h44) begin
            n_err++;
            $display("FAIL pred_follow: got v=%b pc=%h exp v=1 pc=44", if_valid, if_pc);
        end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        id_ready = 1'b0;
        tick();
        tick();
        drive(1'b0, 1'b0, '0, 1'b1, 32'h100);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        n_vec++;
        if (if_valid !== 1'b0 || mem_addr !== 32'h100 || fetch_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL redir_bubble: got v=%b addr=%h cnt=%0d exp v=0 addr=100 cnt=1", if_valid, mem_addr, fetch_cnt);
        end
        tick();
        n_vec++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== mem_fn(32'h100)) begin
            n_err++;
            $display("FAIL redir_target: got v=%b pc=%h inst=%h exp v=1 pc=100 inst=%h", if_valid, if_pc, if_inst, mem_fn(32'h100));
        end
        tick();
        n_vec++;
        if (if_pc !== 32'h104 || fetch_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL redir_follow: got pc=%h cnt=%0d exp pc=104 cnt=2", if_pc, fetch_cnt);
        end
    endtask

    task automatic test_redirect_vs_pred();
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        tick();
        drive(1'b1, 1'b1, 32'h80, 1'b1, 32'h201);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        n_vec++;
        if (if_valid !== 1'b0 || mem_addr !== 32'h200 || fetch_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL redir_pred_bubble: got v=%b addr=%h cnt=%0d exp v=0 addr=200 cnt=3", if_valid, mem_addr, fetch_cnt);
        end
        tick();
        n_vec++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== mem_fn(32'h200)) begin
            n_err++;
            $display("FAIL redir_pred_target: got v=%b pc=%h inst=%h exp v=1 pc=200 inst=%h", if_valid, if_pc, if_inst, mem_fn(32'h200));
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] e;
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            e = 32'hFFFF_FFF8 + 32'(4 * i);
            n_vec++;
            if (if_valid_w !== 1'b1 || if_pc_w !== e || if_inst_w !== mem_fn(e)) begin
                n_err++;
                $display("FAIL wrap_fetch[%0d]: got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                         i, if_valid_w, if_pc_w, if_inst_w, e, mem_fn(e));
            end
        end
        id_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b1, 32'h300);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        n_vec++;
        if (if_valid !== 1'b0 || fetch_cnt !== 32'd0 || mem_addr !== 32'h0 || dbg_state !== 2'(ST_RST)) begin
            n_err++;
            $display("FAIL reset_mid_hold: got v=%b cnt=%0d addr=%h st=%0d exp v=0 cnt=0 addr=0 st=%0d",
                     if_valid, fetch_cnt, mem_addr, dbg_state, ST_RST);
        end
        n_vec++;
        if (if_valid_w !== 1'b0 || fetch_cnt_w !== 32'd0 || mem_addr_w !== 32'hFFFF_FFF8) begin
            n_err++;
            $display("FAIL reset_mid_hold_w: got v=%b cnt=%0d addr=%h exp v=0 cnt=0 addr=fffffff8",
                     if_valid_w, fetch_cnt_w, mem_addr_w);
        end
    endtask

    // Model: the instruction stream is a sequence of PCs; a taken prediction or a redirect
    // restarts it at the aligned target after exactly one empty cycle.
    task automatic test_random();
        logic        m_valid, m_addr_chk, rdy, pt, rv, xfer;
        logic [31:0] m_pc, m_cnt, m_addr, tgt, rpc;
        do_reset();
        m_valid    = 1'b0;
        m_pc       = 32'h0;
        m_cnt      = 32'h0;
        m_addr_chk = 1'b1;
        m_addr     = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(0, 3) != 0);
            pt  = ($urandom_range(0, 7) == 0);
            tgt = $urandom;
            rv  = ($urandom_range(0, 15) == 0);
            rpc = $urandom;
            drive(rdy, pt, tgt, rv, rpc);
            n_vec++;
            if (if_valid !== m_valid) begin
                n_err++;
                $display("FAIL rnd_valid @%0d: got %b exp %b", n, if_valid, m_valid);
            end
            if (m_valid) begin
                n_vec++;
                if (if_pc !== m_pc || if_inst !== mem_fn(m_pc)) begin
                    n_err++;
                    $display("FAIL rnd_inst @%0d: got pc=%h inst=%h exp pc=%h inst=%h", n, if_pc, if_inst, m_pc, mem_fn(m_pc));
                end
            end
            n_vec++;
            if (fetch_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL rnd_cnt @%0d: got %0d exp %0d", n, fetch_cnt, m_cnt);
            end
            if (m_addr_chk) begin
                n_vec++;
                if (mem_addr !== m_addr) begin
                    n_err++;
                    $display("FAIL rnd_addr @%0d: got %h exp %h", n, mem_addr, m_addr);
                end
            end
            xfer       = m_valid && rdy;
            m_addr_chk = 1'b0;
            if (xfer) m_cnt = m_cnt + 32'd1;
            if (rv) begin
                m_pc       = {rpc[31:2], 2'b00};
                m_valid    = 1'b0;
                m_addr_chk = 1'b1;
                m_addr     = m_pc;
            end else if (xfer && pt) begin
                m_pc       = {tgt[31:2], 2'b00};
                m_valid    = 1'b0;
                m_addr_chk = 1'b1;
                m_addr     = m_pc;
            end else if (xfer) begin
                m_pc = m_pc + 32'd4;
            end else if (m_valid) begin
                m_addr_chk = 1'b1;
                m_addr     = m_pc + 32'd4;
            end else begin
                m_valid = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        test_reset();
        test_sequential();
        test_hold_release();
        test_pred_taken();
        test_redirect_hold();
        test_redirect_vs_pred();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4, sequential increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_addr  output  32  fetch address driven to the instruction memory, word-aligned.
REQ-006 mem_rdata  input  32  instruction memory read data, valid exactly one cycle after mem_addr is presented.
REQ-007 if_valid  output  1  if_pc/if_inst hold a valid instruction for decode.
REQ-008 if_pc  output  32  address of the instruction on if_inst.
REQ-009 if_inst  output  32  instruction word.
REQ-010 id_ready  input  1  decode accepts; transfer occurs when if_valid && id_ready.
REQ-011 pred_taken  input  1  branch predictor verdict for the instruction currently on if_pc, sampled only on transfer.
REQ-012 pred_target  input  32  predicted target, sampled with pred_taken.
REQ-013 redirect_valid  input  1  execute-stage mispredict/jump correction, one-cycle pulse.
REQ-014 redirect_pc  input  32  corrected fetch address.
REQ-015 fetch_cnt  output  32  count of instructions transferred to decode.

Function
REQ-016 States SHALL be RST, RUN, HOLD, BUBBLE; a 2-bit encoded state register.
REQ-017 RST: one cycle after reset release, mem_addr=RESET_PC, if_valid=0; next state RUN.
REQ-018 RUN: mem_addr SHALL advance by PC_STEP each cycle a transfer occurs or no valid output is pending; read data appears on if_inst one cycle later with if_valid=1 and if_pc = address issued.
REQ-019 Sustained throughput SHALL be one instruction per cycle while id_ready=1 and no redirect/prediction.
REQ-020 HOLD: when if_valid=1 and id_ready=0, if_pc/if_inst SHALL stay stable, mem_addr SHALL stay unchanged, and the in-flight read word SHALL be captured in a one-entry skid buffer; no instruction lost or duplicated.
REQ-021 Leaving HOLD: on id_ready=1 the held word transfers, the skid entry is presented next cycle without a bubble, then fetch resumes.
REQ-022 Predicted taken: on transfer with pred_taken=1, the sequential in-flight word and skid entry SHALL be discarded, mem_addr=pred_target next cycle, if_valid=0 for exactly one cycle (BUBBLE), target instruction presented the following cycle.
REQ-023 Redirect: redirect_valid at cycle t SHALL discard all in-flight, skid and output state; if_valid=0 at t+1, mem_addr=redirect_pc at t+1, instruction from redirect_pc valid at t+2; state HOLD is abandoned.
REQ-024 Redirect SHALL take priority over a simultaneous predicted-taken transfer; the transfer itself still counts in fetch_cnt.
REQ-025 redirect_pc and pred_target bits [1:0] SHALL be forced to 0 before use.
REQ-026 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
REQ-027 fetch_cnt SHALL increment by 1 per transfer and wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-028 reset SHALL take priority over all inputs, including mid-HOLD and simultaneous redirect.
REQ-029 During reset: state=RST, if_valid=0, if_pc=RESET_PC, if_inst=0, mem_addr=RESET_PC, skid empty, fetch_cnt=0.

Structure
REQ-030 State encoding constants and PC_STEP default SHALL live in shared package fetch_pkg.
REQ-031 The one-entry skid buffer SHALL be a sub-module named fetch_skid_buf (valid, pc, inst registers).
REQ-032 inst_fetch_ctrl SHALL instantiate alongside the existing instruction memory without modifying it.

Verification
REQ-033 Reset release, id_ready=1 -> if_pc sequence 0x0,0x4,0x8 on consecutive cycles starting cycle 2, fetch_cnt=3 after three transfers.
REQ-034 id_ready low 3 cycles at if_pc=0x8 -> if_pc held 0x8, then 0x8,0xC,0x10 back-to-back, no gap or duplicate.
REQ-035 Transfer of 0x10 with pred_taken=1, pred_target=0x43 -> one bubble, next if_pc=0x40, 0x14 never presented.
REQ-036 redirect_valid with redirect_pc=0x100 during HOLD -> if_valid=0 next cycle, then if_pc=0x100; held word dropped, not counted.
REQ-037 Simultaneous redirect (0x200) and pred_taken (0x80) transfer -> next valid if_pc=0x200, fetch_cnt +1.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> if_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0; reset asserted mid-HOLD -> if_valid=0 next cycle, fetch_cnt=0.
